// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// A double-buffered display word is lit one digit at a time; new data taken
// through a valid/ready handshake is committed only on a frame boundary
// (or straight away while idle) so a frame is never torn.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DATA_WIDTH   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 500,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic [NUM_DIGITS*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]            blank_mask,
    input  logic                             lz_en,
    output logic [DATA_WIDTH:0]              digit_value,
    output logic [NUM_DIGITS-1:0]            anode_n,
    output logic [IDX_W-1:0]                 digit_idx,
    output logic                             frame_done
);

    localparam int WORD_W  = NUM_DIGITS * DATA_WIDTH;
    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [DATA_WIDTH:0] BLANK = {1'b1, {DATA_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        SHOW
    } state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [IDX_W-1:0]        idx_nx;
    logic                    frame_end;

    logic [WORD_W-1:0]       act_data, act_data_nx, pend_data;
    logic [NUM_DIGITS-1:0]   act_mask, act_mask_nx, pend_mask;
    logic                    act_lz, act_lz_nx, pend_lz;
    logic                    pending, pending_nx;
    logic                    xfer, commit;

    logic [NUM_DIGITS-1:0]   anode_nx;
    logic [DATA_WIDTH:0]     value_nx;

    // Decoder code for digit i: forced blank by the mask, or blanked as a
    // leading zero when every nibble from the top down to i is zero (never
    // for digit 0), otherwise the plain nibble.
    function automatic logic [DATA_WIDTH:0] code_of(
        input logic [WORD_W-1:0]     d,
        input logic [NUM_DIGITS-1:0] m,
        input logic                  lz,
        input logic [IDX_W-1:0]      i
    );
        logic                  lead_zero;
        logic                  mbit;
        logic [DATA_WIDTH-1:0] nib;
        lead_zero = 1'b1;
        mbit      = 1'b0;
        nib       = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (IDX_W'(k) == i) begin
                nib  = d[k*DATA_WIDTH +: DATA_WIDTH];
                mbit = m[k];
            end
            if (IDX_W'(k) >= i && d[k*DATA_WIDTH +: DATA_WIDTH] != '0)
                lead_zero = 1'b0;
        end
        if (mbit || (lz && i != '0 && lead_zero))
            return BLANK;
        return {1'b0, nib};
    endfunction

    // Scan sequencing: next state, slot counter and digit index.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + CNT_W'(1);
        idx_nx    = digit_idx;
        frame_end = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = (GUARD_CYCLES == 0) ? SHOW : GUARD;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
                GUARD: begin
                    if (cnt == CNT_W'(GUARD_CYCLES - 1)) begin
                        state_nx = SHOW;
                        cnt_nx   = '0;
                    end
                end
                SHOW: begin
                    if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                        // With no guard time SHOW follows SHOW, so the counter
                        // reload is tied to slot end rather than state change.
                        state_nx = (GUARD_CYCLES == 0) ? SHOW : GUARD;
                        cnt_nx   = '0;
                        if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                            idx_nx    = '0;
                            frame_end = 1'b1;
                        end else begin
                            idx_nx = digit_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            endcase
        end
    end

    // Handshake and commit of the pending set into the active set.
    always_comb begin
        xfer        = load_valid && !pending;
        commit      = pending && ((state == IDLE) || frame_end);
        pending_nx  = pending;
        act_data_nx = act_data;
        act_mask_nx = act_mask;
        act_lz_nx   = act_lz;
        if (xfer)
            pending_nx = 1'b1;
        else if (commit)
            pending_nx = 1'b0;
        if (commit) begin
            act_data_nx = pend_data;
            act_mask_nx = pend_mask;
            act_lz_nx   = pend_lz;
        end
    end

    // Next display outputs, computed from next state so the pins are registered.
    always_comb begin
        anode_nx = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            anode_nx[i] = !((state_nx == SHOW) && (idx_nx == IDX_W'(i)));
        value_nx = (state_nx == IDLE) ? BLANK
                                      : code_of(act_data_nx, act_mask_nx, act_lz_nx, idx_nx);
    end

    // Scan state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            digit_idx <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            digit_idx <= idx_nx;
        end
    end

    // Active and pending display word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            pend_data <= '0;
            pend_mask <= '0;
            pend_lz   <= 1'b0;
            act_data  <= '0;
            act_mask  <= '0;
            act_lz    <= 1'b0;
        end else begin
            pending  <= pending_nx;
            act_data <= act_data_nx;
            act_mask <= act_mask_nx;
            act_lz   <= act_lz_nx;
            if (xfer) begin
                pend_data <= data_in;
                pend_mask <= blank_mask;
                pend_lz   <= lz_en;
            end
        end
    end

    // Registered output pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_n     <= '1;
            digit_value <= BLANK;
            frame_done  <= 1'b0;
            load_ready  <= 1'b1;
        end else begin
            anode_n     <= anode_nx;
            digit_value <= value_nx;
            frame_done  <= frame_end;
            load_ready  <= !pending_nx;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: stimulus pushes expected digit
// slots, a negedge monitor reconstructs observed slots and compares them.
module tb_seven_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int DW = 4;
    localparam int RD = 4;
    localparam int GC = 1;
    localparam logic [DW:0] BLANK = 5'b10000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              load_valid;
    logic              load_ready;
    logic [ND*DW-1:0]  data_in;
    logic [ND-1:0]     blank_mask;
    logic              lz_en;
    logic [DW:0]       digit_value;
    logic [ND-1:0]     anode_n;
    logic [1:0]        digit_idx;
    logic              frame_done;

    typedef struct {
        int          digit;
        logic [DW:0] code;
        int          len;     // -1: not checked
        int          guard;   // -1: not checked
    } slot_t;

    slot_t       exp_q[$];
    int          checks = 0;
    int          fails  = 0;

    logic [15:0] m_data;
    logic [3:0]  m_mask;
    logic        m_lz;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DATA_WIDTH  (DW),
        .REFRESH_DIV (RD),
        .GUARD_CYCLES(GC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_in    (data_in),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .digit_value(digit_value),
        .anode_n    (anode_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: what digit k should show for a given display word.
    function automatic logic [DW:0] model_code(input logic [15:0] d, input logic [3:0] m,
                                               input logic lz, input int k);
        logic [15:0] upper;
        upper = d >> (DW * k);
        if (m[k]) return BLANK;
        if (lz && k != 0 && upper == 16'h0) return BLANK;
        return {1'b0, upper[DW-1:0]};
    endfunction

    task automatic push_slot(input int k, input int len, input int guard);
        slot_t s;
        s.digit = k;
        s.code  = model_code(m_data, m_mask, m_lz, k);
        s.len   = len;
        s.guard = guard;
        exp_q.push_back(s);
    endtask

    task automatic push_frame(input bit first);
        for (int k = 0; k < ND; k++)
            push_slot(k, RD, (first && k == 0) ? -1 : GC);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    logic en_smp = 1'b0;
    always @(posedge clk) en_smp <= enable;

    int          lit_prev = -1;
    int          run_len  = 0;
    int          off_len  = 0;
    int          guard_before = 0;
    logic [DW:0] code_cur;

    // Rebuilds lit slots from the pins and scores them against the queue.
    always @(negedge clk) begin : monitor
        int    lit;
        int    zeros;
        bit    fd_exp;
        slot_t e;
        if (!rst_n) begin
            lit_prev = -1;
            run_len  = 0;
            off_len  = 0;
        end else begin
            lit   = -1;
            zeros = 0;
            for (int i = 0; i < ND; i++)
                if (!anode_n[i]) begin
                    zeros++;
                    lit = i;
                end
            chk("anode_overlap", zeros <= 1, 1);
            if (lit >= 0) chk("digit_idx", digit_idx, lit);
            fd_exp = (lit_prev == ND - 1) && (run_len == RD) && (lit != lit_prev) && en_smp;
            chk("frame_done", frame_done, fd_exp);
            if (lit == lit_prev) begin
                if (lit >= 0) begin
                    run_len++;
                    chk("code_stable", digit_value, code_cur);
                end else begin
                    off_len++;
                end
            end else begin
                if (lit_prev >= 0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_slot: digit %0d code %b seen, none required",
                                 lit_prev, code_cur);
                    end else begin
                        e = exp_q.pop_front();
                        chk("slot_digit", lit_prev, e.digit);
                        chk("slot_code", code_cur, e.code);
                        if (e.len >= 0)   chk("slot_len", run_len, e.len);
                        if (e.guard >= 0) chk("slot_guard", guard_before, e.guard);
                    end
                end
                if (lit >= 0) begin
                    guard_before = (lit_prev >= 0) ? 0 : off_len;
                    run_len      = 1;
                    code_cur     = digit_value;
                end else begin
                    off_len = 1;
                end
            end
            lit_prev = lit;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_chk(input string tag);
        chk({tag, "_anode"}, anode_n, 4'hF);
        chk({tag, "_value"}, digit_value, BLANK);
        chk({tag, "_idx"}, digit_idx, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic start_scan();
        int n;
        n = 0;
        push_frame(1);
        enable = 1'b1;
        do begin
            step();
            n++;
        end while (anode_n == 4'hF && n < 20);
        chk("first_anode_delay", n, GC + 1);
    endtask

    task automatic drain(input bit pend);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
            if (pend) chk("load_ready_pending", load_ready, exp_q.size() == 0);
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: %0d slots outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] m, input logic l);
        data_in    = d;
        blank_mask = m;
        lz_en      = l;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        data_in    = 16'($urandom);
        blank_mask = 4'($urandom);
        lz_en      = 1'($urandom);
        chk("load_ready_after_xfer", load_ready, 0);
    endtask

    // Called at the start of a frame: old data for this frame, new data next.
    task automatic load_mid(input logic [15:0] d, input logic [3:0] m, input logic l);
        int r;
        r = $urandom_range(0, 12);
        push_frame(0);
        repeat (r) step();
        do_load(d, m, l);
        drain(1);
        m_data = d;
        m_mask = m;
        m_lz   = l;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] rd;
        logic [3:0]  rm;
        rst_n      = 1'b0;
        enable     = 1'b0;
        load_valid = 1'b0;
        data_in    = '0;
        blank_mask = '0;
        lz_en      = 1'b0;
        m_data     = '0;
        m_mask     = '0;
        m_lz       = 1'b0;

        step();
        step();
        idle_chk("rst");
        chk("rst_load_ready", load_ready, 1);
        rst_n = 1'b1;
        step();
        idle_chk("post_rst");

        // Scan with reset contents: two frames of zeros.
        start_scan();
        drain(0);
        push_frame(0);
        drain(0);
        enable = 1'b0;
        step();
        idle_chk("disable");

        // Load while idle commits on the following cycle.
        do_load(16'h1A3F, 4'b0000, 1'b0);
        step();
        chk("idle_commit_ready", load_ready, 1);
        m_data = 16'h1A3F;
        m_mask = 4'b0000;
        m_lz   = 1'b0;
        start_scan();
        drain(0);

        // Mid-frame loads commit at the next frame boundary.
        load_mid(16'h00B0, 4'b0000, 1'b1);
        load_mid(16'h0000, 4'b0000, 1'b1);
        load_mid(16'h4321, 4'b0101, 1'b0);
        for (int it = 0; it < 8; it++) begin
            rd = 16'($urandom);
            if ($urandom_range(0, 1) == 1) rd = rd & (16'hFFFF >> (4 * $urandom_range(1, 3)));
            rm = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom);
            load_mid(rd, rm, 1'($urandom));
        end
        push_frame(0);
        drain(0);

        // Drop enable during digit 2's lit slot.
        push_slot(0, RD, GC);
        push_slot(1, RD, GC);
        push_slot(2, -1, GC);
        repeat (12) step();
        enable = 1'b0;
        step();
        idle_chk("drop");
        chk("drop_slots_left", exp_q.size(), 0);
        step();
        start_scan();
        drain(0);

        // Asynchronous reset mid-slot with a load pending.
        push_frame(0);
        do_load(16'hFFFF, 4'b0000, 1'b0);
        step();
        step();
        chk("pre_rst_lit", anode_n, 4'b1110);
        #2;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        idle_chk("async_rst");
        chk("async_rst_ready", load_ready, 1);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        m_data = '0;
        m_mask = '0;
        m_lz   = 1'b0;
        step();
        start_scan();
        drain(0);
        push_frame(0);
        drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
